// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encodings
// and the helpers that size the iteration counter from the operand widths.
package mul_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Number of RUN iterations: k multiplier bits are retired per iteration.
   function automatic int iter_count(input int mm, input int kk);
      return mm / kk;
   endfunction

   // Counter width; never below one bit, even for a single-iteration build.
   function automatic int cnt_width(input int mm, input int kk);
      int c;
      c = $clog2(mm / kk);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/shift_add_mul_rca.sv
// Plain ripple-carry adder, w bits wide, with a carry-in and no carry-out.
// The multiplier sizes it so that the sum can never overflow.
module shift_add_mul_rca #(
   parameter int w = 9
) (
   input  logic [w-1:0] x,
   input  logic [w-1:0] y,
   input  logic         cin,
   output logic [w-1:0] s
);

   logic [w-1:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < w; i++) begin : g_bit
      assign s[i] = x[i] ^ y[i] ^ c[i];
      if (i < w - 1) begin : g_carry
         assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

endmodule

// File: rtl/shift_add_mul.sv
// Iterative sign-magnitude multiplier. Operand magnitudes are captured on
// accept, k bits of B are retired per RUN cycle through one (n+k)-bit adder,
// and the sign is reapplied when the product is loaded into P.
//
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both 1; an output transfer happens on a rising edge where
// out_valid and out_ready are both 1. in_ready is high only in IDLE and
// out_valid only in DONE, so the two transfers can never share an edge, and
// P/out_valid do not change while out_valid is waiting on out_ready.
module shift_add_mul
   import mul_pkg::*;
#(
   parameter int n = 8,
   parameter int m = 8,
   parameter int k = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [n-1:0]   A,
   input  logic [m-1:0]   B,
   input  logic           signed_mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [n+m-1:0] P
);

   localparam int iters = iter_count(m, k);
   localparam int cw    = cnt_width(m, k);
   localparam int w     = n + m;
   localparam int pw    = n + k;
   localparam logic [cw-1:0] last_cnt = cw'(iters - 1);

   if (n < 2 || m < 2 || k < 1 || k > m || (m % k) != 0) begin : g_bad_param
      $error("shift_add_mul: illegal parameters n=%0d m=%0d k=%0d", n, m, k);
   end

   // Control state kept together so the FSM position is visible as one value.
   typedef struct packed {
      logic [1:0]    state;
      logic [cw-1:0] cnt;
      logic          sgn;
   } ctl_t;

   ctl_t          ctl;
   logic [n-1:0]  a_abs;
   logic [n-1:0]  a_in_abs;
   logic [m-1:0]  b_in_abs;
   logic [w-1:0]  acc;
   logic [w-1:0]  acc_next;
   logic [w-1:0]  prod;
   logic [pw-1:0] pp;
   logic [pw-1:0] sum;

   // Magnitudes of the presented operands; -2^(x-1) maps to 2^(x-1) exactly
   // because the result is read as unsigned.
   always_comb begin
      a_in_abs = (signed_mode && A[n-1]) ? -A : A;
      b_in_abs = (signed_mode && B[m-1]) ? -B : B;
   end

   // k-row AND array: |A| gated by each of the k low accumulator bits.
   always_comb begin
      pp = '0;
      for (int j = 0; j < k; j++) begin
         pp = pp + (pw'(a_abs & {n{acc[j]}}) << j);
      end
   end

   shift_add_mul_rca #(.w(pw)) u_rca (
      .x   (pw'(acc[w-1:m])),
      .y   (pp),
      .cin (1'b0),
      .s   (sum)
   );

   if (k == m) begin : g_full_shift
      assign acc_next = sum;
   end else begin : g_part_shift
      assign acc_next = {sum, acc[m-1:k]};
   end

   assign prod      = ctl.sgn ? -acc_next : acc_next;
   assign in_ready  = (ctl.state == IDLE);
   assign out_valid = (ctl.state == DONE);

   // FSM and datapath registers: accept in IDLE, iterate in RUN, hold in DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctl.state <= IDLE;
         ctl.cnt   <= '0;
         ctl.sgn   <= 1'b0;
         a_abs     <= '0;
         acc       <= '0;
         P         <= '0;
      end else begin
         case (ctl.state)
            IDLE: begin
               if (in_valid) begin
                  a_abs     <= a_in_abs;
                  ctl.sgn   <= (A[n-1] ^ B[m-1]) & signed_mode;
                  acc       <= {{n{1'b0}}, b_in_abs};
                  ctl.cnt   <= '0;
                  ctl.state <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               if (ctl.cnt == last_cnt) begin
                  P         <= prod;
                  ctl.state <= DONE;
               end else begin
                  ctl.cnt <= ctl.cnt + cw'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  ctl.state <= IDLE;
               end
            end
            default: ctl.state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mul.sv
// Bench for shift_add_mul: one instance per (n, m, k) with n, m in {4, 8, 13}
// and every legal k. Each instance gets reset checks, fixed corner operands,
// a random sweep in both modes with stray in_valid pulses and output stalls,
// and a reset that abandons an operation in flight. Expected products come
// from a signed 64-bit multiply model through a per-instance queue.
module tb_shift_add_mul;

   localparam int NCFG = 27;

   logic clk = 1'b0;
   int   cycle = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt = 0;

   logic [7:0] dir_a [5] = '{8'd13, 8'd255, 8'h80, 8'hFD, 8'h80};
   logic [7:0] dir_b [5] = '{8'd11, 8'd255, 8'h80, 8'h05, 8'h7F};
   logic       dir_m [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   // clock and cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_n
      for (genvar gj = 0; gj < 3; gj++) begin : g_m
         for (genvar gk = 1; gk <= 13; gk++) begin : g_k
            localparam int N = (gi == 0) ? 4 : (gi == 1) ? 8 : 13;
            localparam int M = (gj == 0) ? 4 : (gj == 1) ? 8 : 13;
            if (gk <= M && (M % gk) == 0) begin : g_cfg
               localparam int K = gk;
               localparam int W = N + M;
               localparam int L = M / K;

               logic         rst_n, in_valid, in_ready, signed_mode, out_valid, out_ready;
               logic [N-1:0] a;
               logic [M-1:0] b;
               logic [W-1:0] p;
               logic [W-1:0] exp_q [$];
               int           acc_q [$];
               logic         holding = 1'b0;
               logic         prev_ov = 1'b0;
               logic [W-1:0] held_p = '0;

               shift_add_mul #(.n(N), .m(M), .k(K)) dut (
                  .clk         (clk),
                  .rst_n       (rst_n),
                  .in_valid    (in_valid),
                  .in_ready    (in_ready),
                  .A           (a),
                  .B           (b),
                  .signed_mode (signed_mode),
                  .out_valid   (out_valid),
                  .out_ready   (out_ready),
                  .P           (p)
               );

               function automatic string tg(input string s);
                  return $sformatf("%s[n%0d m%0d k%0d]", s, N, M, K);
               endfunction

               function automatic logic [W-1:0] model(input logic [N-1:0] ta,
                                                      input logic [M-1:0] tb,
                                                      input logic tm);
                  longint sa, sb;
                  sa = longint'(ta);
                  sb = longint'(tb);
                  if (tm && ta[N-1]) sa = sa - (longint'(1) << N);
                  if (tm && tb[M-1]) sb = sb - (longint'(1) << M);
                  return W'(sa * sb);
               endfunction

               function automatic logic [N-1:0] pick_a();
                  logic [N-1:0] v;
                  case ($urandom_range(0, 4))
                     0:       v = '0;
                     1:       v = '1;
                     2:       begin v = '0; v[N-1] = 1'b1; end
                     default: v = N'($urandom);
                  endcase
                  return v;
               endfunction

               function automatic logic [M-1:0] pick_b();
                  logic [M-1:0] v;
                  case ($urandom_range(0, 4))
                     0:       v = '0;
                     1:       v = '1;
                     2:       begin v = '0; v[M-1] = 1'b1; end
                     default: v = M'($urandom);
                  endcase
                  return v;
               endfunction

               task automatic junk_inputs(input logic ready_val);
                  in_valid    = 1'($urandom_range(0, 1));
                  a           = N'($urandom);
                  b           = M'($urandom);
                  signed_mode = 1'($urandom_range(0, 1));
                  out_ready   = ready_val;
               endtask

               // present operands and take the accept edge
               task automatic issue(input logic [N-1:0] ta, input logic [M-1:0] tb,
                                    input logic tm, input bit keep);
                  int guard = 0;
                  in_valid = 1'b1; a = ta; b = tb; signed_mode = tm; out_ready = 1'b0;
                  while (!in_ready && guard < 8) begin
                     @(posedge clk); #1;
                     guard++;
                  end
                  check(tg("in_ready"), 64'(in_ready), 64'd1);
                  if (keep) exp_q.push_back(model(ta, tb, tm));
                  @(posedge clk); #1;
                  in_valid = 1'b0;
               endtask

               // run to DONE under junk inputs, stall a little, then deliver
               task automatic complete();
                  int guard = 0;
                  while (!out_valid && guard < L + 4) begin
                     junk_inputs(1'($urandom_range(0, 1)));
                     @(posedge clk); #1;
                     guard++;
                  end
                  check(tg("out_valid_seen"), 64'(out_valid), 64'd1);
                  repeat ($urandom_range(0, 3)) begin
                     junk_inputs(1'b0);
                     @(posedge clk); #1;
                  end
                  in_valid  = 1'b0;
                  out_ready = 1'b1;
                  @(posedge clk); #1;
                  out_ready = 1'b0;
                  check(tg("ov_clear"), 64'(out_valid), 64'd0);
                  check(tg("idle_ready"), 64'(in_ready), 64'd1);
               endtask

               // monitor: latency, held output under stall, scoreboard pop
               always @(negedge clk) begin
                  if (rst_n) begin
                     if (holding) check(tg("hold"), 64'({out_valid, p}), 64'({1'b1, held_p}));
                     if (in_valid && in_ready) acc_q.push_back(cycle + 1);
                     if (out_valid && !prev_ov) begin
                        if (acc_q.size() > 0) check(tg("latency"), 64'(cycle - acc_q.pop_front()), 64'(L));
                        else check(tg("spurious_ov"), 64'(out_valid), 64'd0);
                     end
                     if (out_valid && out_ready) begin
                        if (exp_q.size() > 0) check(tg("product"), 64'(p), 64'(exp_q.pop_front()));
                        else check(tg("spurious_p"), 64'(out_valid), 64'd0);
                     end
                  end
                  holding = rst_n && out_valid && !out_ready;
                  held_p  = p;
                  prev_ov = rst_n && out_valid;
               end

               // driver
               initial begin
                  rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
                  signed_mode = 1'b0; out_ready = 1'b0;
                  repeat (2) @(posedge clk);
                  #1;
                  check(tg("rst_p"), 64'(p), 64'd0);
                  check(tg("rst_ov"), 64'(out_valid), 64'd0);
                  check(tg("rst_ir"), 64'(in_ready), 64'd1);
                  rst_n = 1'b1;

                  for (int i = 0; i < 5; i++) begin
                     issue(N'(dir_a[i]), M'(dir_b[i]), dir_m[i], 1'b1);
                     complete();
                  end
                  for (int i = 0; i < 30; i++) begin
                     issue(pick_a(), pick_b(), 1'($urandom_range(0, 1)), 1'b1);
                     complete();
                  end

                  // abandon an operation two edges after accept
                  issue(pick_a(), pick_b(), 1'b1, 1'b0);
                  repeat (2) begin
                     junk_inputs(1'b0);
                     @(posedge clk); #1;
                  end
                  rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                  exp_q.delete();
                  acc_q.delete();
                  @(posedge clk); #1;
                  check(tg("midrst_p"), 64'(p), 64'd0);
                  check(tg("midrst_ov"), 64'(out_valid), 64'd0);
                  check(tg("midrst_ir"), 64'(in_ready), 64'd1);
                  rst_n = 1'b1;
                  issue(pick_a(), pick_b(), 1'($urandom_range(0, 1)), 1'b1);
                  complete();
                  repeat (2) @(posedge clk);
                  check(tg("queue_drained"), 64'(exp_q.size()), 64'd0);
                  done_cnt++;
               end
            end
         end
      end
   end

   // end of run: wait for every instance with a cycle budget
   initial begin
      while (done_cnt < NCFG && cycle < 50000) @(posedge clk);
      check("all_configs_done", 64'(done_cnt), 64'(NCFG));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
